// File: rtl/matrix_3x3_gen.sv
// 3x3 neighbourhood generator: two column-addressed line buffers feed a 3x3 shift window,
// one window is emitted per accepted interior pixel, two cycles after that pixel is accepted.
module matrix_3x3_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   s_pixel_data,
  input  logic                    s_pixel_valid,
  input  logic                    s_sof,
  output logic [9*DATA_WIDTH-1:0] m_matrix_data,
  output logic                    m_matrix_valid,
  output logic                    m_matrix_eof
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]    col_r, cur_col_s, nxt_col_s;
  logic [RW-1:0]    row_r, cur_row_s, nxt_row_s;
  logic             accept_s, interior_s, last_s;

  logic [DW-1:0]    lb0_r [IMG_WIDTH];
  logic [DW-1:0]    lb1_r [IMG_WIDTH];
  logic [DW-1:0]    rd0_r, rd1_r, pix1_r;
  logic             acc1_r, out1_r, eof1_r;
  logic             out2_r, eof2_r;
  logic [9*DW-1:0]  win_r, win_next_s;

  // Position of the pixel being accepted now (s_sof forces the origin) and the one after it.
  always_comb begin
    accept_s   = s_pixel_valid & resetn;
    cur_col_s  = s_sof ? {CW{1'b0}} : col_r;
    cur_row_s  = s_sof ? {RW{1'b0}} : row_r;
    interior_s = (cur_row_s >= ROW_TWO) && (cur_col_s >= COL_TWO);
    last_s     = (cur_col_s == COL_LAST) && (cur_row_s == ROW_LAST);
    nxt_col_s  = cur_col_s;
    nxt_row_s  = cur_row_s;
    if (cur_col_s == COL_LAST) begin
      nxt_col_s = {CW{1'b0}};
      if (cur_row_s == ROW_LAST) begin
        nxt_row_s = {RW{1'b0}};
      end else begin
        nxt_row_s = cur_row_s + RW'(1);
      end
    end else begin
      nxt_col_s = cur_col_s + CW'(1);
    end
  end

  // Raster position counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else if (s_pixel_valid) begin
      col_r <= nxt_col_s;
      row_r <= nxt_row_s;
    end
  end

  // Line buffers (read-before-write) and the stage-1 column capture; RAM is never cleared.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb0_r[cur_col_s] <= lb1_r[cur_col_s];
      lb1_r[cur_col_s] <= s_pixel_data;
      rd0_r            <= lb0_r[cur_col_s];
      rd1_r            <= lb1_r[cur_col_s];
      pix1_r           <= s_pixel_data;
    end
  end

  // Window shift: columns move toward j=0 and the fresh column enters at j=2.
  always_comb begin
    win_next_s = win_r;
    for (int i = 0; i < 3; i++) begin
      win_next_s[(i*3+0)*DW +: DW] = win_r[(i*3+1)*DW +: DW];
      win_next_s[(i*3+1)*DW +: DW] = win_r[(i*3+2)*DW +: DW];
    end
    win_next_s[2*DW +: DW] = rd0_r;
    win_next_s[5*DW +: DW] = rd1_r;
    win_next_s[8*DW +: DW] = pix1_r;
  end

  // Control pipeline, window register and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc1_r         <= 1'b0;
      out1_r         <= 1'b0;
      eof1_r         <= 1'b0;
      out2_r         <= 1'b0;
      eof2_r         <= 1'b0;
      win_r          <= {(9*DW){1'b0}};
      m_matrix_data  <= {(9*DW){1'b0}};
      m_matrix_valid <= 1'b0;
      m_matrix_eof   <= 1'b0;
    end else begin
      acc1_r         <= s_pixel_valid;
      out1_r         <= s_pixel_valid & interior_s;
      eof1_r         <= s_pixel_valid & last_s;
      out2_r         <= acc1_r & out1_r;
      eof2_r         <= acc1_r & eof1_r;
      if (acc1_r) begin
        win_r <= win_next_s;
      end
      m_matrix_valid <= out2_r;
      m_matrix_eof   <= out2_r & eof2_r;
      if (out2_r) begin
        m_matrix_data <= win_r;
      end
    end
  end

endmodule
